// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32IM control unit: states, ALU codes,
// datapath select values, opcodes and the branch-condition helper.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_LUI, S_ALUWB, S_MEMADR,
    S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_JAL, S_JALR1, S_JALR2
  } state_t;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG1  = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REG2  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_ONE   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Flags come from A-B compare; less-than is derived as neither greater nor equal.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                        input logic gt, input logic gtu);
    case (funct3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return !gt && !eq;
      3'b101:  return gt || eq;
      3'b110:  return !gtu && !eq;
      3'b111:  return gtu || eq;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decode.sv
// Combinational funct3/funct7 to ALU operation map for R-type and OP-IMM.
// Zero latency, no flow control.
module multicycle_control_fsm_alu_op_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_is_rtype,
  output logic [4:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    if (i_is_rtype && (i_funct7 == FUNCT7_MULDIV)) begin
      case (i_funct3)
        3'b000:  o_alu_control = ALU_MUL;
        3'b001:  o_alu_control = ALU_MULH;
        3'b010:  o_alu_control = ALU_MULHSU;
        3'b011:  o_alu_control = ALU_MULHU;
        3'b100:  o_alu_control = ALU_DIV;
        3'b101:  o_alu_control = ALU_DIVU;
        3'b110:  o_alu_control = ALU_REM;
        default: o_alu_control = ALU_REMU;
      endcase
    end else begin
      case (i_funct3)
        // ADDI has no SUB form: immediate bits in funct7 must not flip it.
        3'b000:  o_alu_control = (i_is_rtype && i_funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  o_alu_control = ALU_SLL;
        3'b010:  o_alu_control = ALU_SLT;
        3'b011:  o_alu_control = ALU_SLTU;
        3'b100:  o_alu_control = ALU_XOR;
        3'b101:  o_alu_control = i_funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  o_alu_control = ALU_OR;
        default: o_alu_control = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32IM control FSM; Moore outputs except branch PCWrite.
// 3-5 cycles per instruction, no stall input; reset=0 forces FETCH and kills writes.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OpCode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Eq,
  input  logic       Gt,
  input  logic       GtU,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [4:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_alu_op;
  logic       w_pc_write, w_mem_write, w_ir_write, w_reg_write;

  multicycle_control_fsm_alu_op_decode u_alu_op_decode (
    .i_funct3      (funct3),
    .i_funct7      (funct7),
    .i_is_rtype    (r_state == S_EXE_R),
    .o_alu_control (w_alu_op)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    AdrSrc      = ADR_PC;
    ResultSrc   = RES_ALUOUT;
    ALUControl  = ALU_ADD;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG2;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        ALUSrcB    = SRCB_ONE;
        ResultSrc  = RES_ALURESULT;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (OpCode)
          OP_RTYPE:           w_next = S_EXE_R;
          OP_ITYPE:           w_next = S_EXE_I;
          OP_LOAD, OP_STORE:  w_next = S_MEMADR;
          OP_BRANCH:          w_next = S_BRANCH;
          OP_JAL:             w_next = S_JAL;
          OP_JALR:            w_next = S_JALR1;
          OP_LUI:             w_next = S_LUI;
          OP_AUIPC:           w_next = S_ALUWB;
          default:            w_next = S_FETCH;
        endcase
      end
      S_EXE_R: begin
        ALUSrcA    = SRCA_REG1;
        ALUControl = w_alu_op;
        w_next     = S_ALUWB;
      end
      S_EXE_I: begin
        ALUSrcA    = SRCA_REG1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = w_alu_op;
        w_next     = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ALUWB;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_MEMADR: begin
        ALUSrcA = SRCA_REG1;
        ALUSrcB = SRCB_IMM;
        w_next  = (OpCode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = ADR_RESULT;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = ADR_RESULT;
        w_mem_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_REG1;
        ALUControl = ALU_SUB;
        w_pc_write = branch_taken(funct3, Eq, Gt, GtU);
      end
      // PC takes the target already in ALUOut while the ALU forms the link value.
      S_JAL: begin
        w_pc_write = 1'b1;
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_ONE;
        w_next     = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA    = SRCA_REG1;
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        w_pc_write = 1'b1;
        w_next     = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_ONE;
        ResultSrc   = RES_ALURESULT;
        w_reg_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWrite  = w_pc_write  & reset;
  assign MemWrite = w_mem_write & reset;
  assign IRWrite  = w_ir_write  & reset;
  assign RegWrite = w_reg_write & reset;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Random instruction stream against a per-instruction expected-cycle model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] OpCode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       Eq = 1'b0, Gt = 1'b0, GtU = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [4:0] ALUControl;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .funct3(funct3), .funct7(funct7),
    .Eq(Eq), .Gt(Gt), .GtU(GtU), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  wire [15:0] w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                       ALUSrcA, ALUSrcB, RegWrite};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rec(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [4:0] alu, input logic [1:0] a,
                                      input logic [1:0] b, input logic rw);
    return {pcw, adr, mw, irw, rs, alu, a, b, rw};
  endfunction

  // ALU op derived from the ISA tables: base ops in funct3 order, M ops at 10+funct3.
  function automatic logic [4:0] alu_of(input bit rtype, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [4:0] base[8];
    base = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    if (rtype && f7 == 7'b0000001) return 5'd10 + {2'b00, f3};
    if (f3 == 3'd0) return (rtype && f7[5]) ? 5'd1 : 5'd0;
    if (f3 == 3'd5) return f7[5] ? 5'd7 : 5'd6;
    return base[f3];
  endfunction

  function automatic bit taken_of(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic build_expected(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a,
                                input logic [31:0] b);
    logic [15:0] wb;
    logic [15:0] memadr;
    wb     = rec(0, 0, 0, 0, 2'b00, 5'd0, 2'b00, 2'b00, 1);
    memadr = rec(0, 0, 0, 0, 2'b00, 5'd0, 2'b10, 2'b01, 0);
    exp_q.delete();
    exp_q.push_back(rec(1, 0, 0, 1, 2'b10, 5'd0, 2'b00, 2'b10, 0));
    exp_q.push_back(rec(0, 0, 0, 0, 2'b00, 5'd0, 2'b01, 2'b01, 0));
    case (op)
      7'b0110011: begin
        exp_q.push_back(rec(0, 0, 0, 0, 2'b00, alu_of(1, f3, f7), 2'b10, 2'b00, 0));
        exp_q.push_back(wb);
      end
      7'b0010011: begin
        exp_q.push_back(rec(0, 0, 0, 0, 2'b00, alu_of(0, f3, f7), 2'b10, 2'b01, 0));
        exp_q.push_back(wb);
      end
      7'b0110111: begin
        exp_q.push_back(rec(0, 0, 0, 0, 2'b00, 5'd0, 2'b11, 2'b01, 0));
        exp_q.push_back(wb);
      end
      7'b0010111: exp_q.push_back(wb);
      7'b0000011: begin
        exp_q.push_back(memadr);
        exp_q.push_back(rec(0, 1, 0, 0, 2'b00, 5'd0, 2'b00, 2'b00, 0));
        exp_q.push_back(rec(0, 0, 0, 0, 2'b01, 5'd0, 2'b00, 2'b00, 1));
      end
      7'b0100011: begin
        exp_q.push_back(memadr);
        exp_q.push_back(rec(0, 1, 1, 0, 2'b00, 5'd0, 2'b00, 2'b00, 0));
      end
      7'b1100011:
        exp_q.push_back(rec(taken_of(f3, a, b), 0, 0, 0, 2'b00, 5'd1, 2'b10, 2'b00, 0));
      7'b1101111: begin
        exp_q.push_back(rec(1, 0, 0, 0, 2'b00, 5'd0, 2'b01, 2'b10, 0));
        exp_q.push_back(wb);
      end
      7'b1100111: begin
        exp_q.push_back(rec(1, 0, 0, 0, 2'b10, 5'd0, 2'b10, 2'b01, 0));
        exp_q.push_back(rec(0, 0, 0, 0, 2'b10, 5'd0, 2'b01, 2'b10, 1));
      end
      default: ;
    endcase
  endtask

  // Entered just after a negedge; returns at the negedge that starts the next cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a,
                           input logic [31:0] b, input int abort_at);
    build_expected(op, f3, f7, a, b);
    OpCode = op; funct3 = f3; funct7 = f7;
    Eq = (a == b); Gt = ($signed(a) > $signed(b)); GtU = (a > b);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == abort_at) return;
      #1 check_eq($sformatf("%s op=%b f3=%0d f7=%b cyc%0d", name, op, f3, f7, k),
                  {16'd0, w_obs}, {16'd0, exp_q[k]});
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string name, input int n);
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1 check_eq($sformatf("%s wen cyc%0d", name, k),
                  {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hffff_ffff;
      3:       return 32'h8000_0000;
      4:       return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] ops[13];
    logic [6:0] f7s[4];
    logic [31:0] a, b;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000, 7'b0001111,
            7'b1110011};
    f7s = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000000};

    #2 reset = 1'b0;
    @(negedge clk);
    do_reset("por", 3);

    run_instr("sub",   7'b0110011, 3'd0, 7'b0100000, 32'd0, 32'd0, -1);
    run_instr("div",   7'b0110011, 3'd4, 7'b0000001, 32'd0, 32'd0, -1);
    run_instr("addi",  7'b0010011, 3'd0, 7'b0100000, 32'd0, 32'd0, -1);
    run_instr("srai",  7'b0010011, 3'd5, 7'b0100000, 32'd0, 32'd0, -1);
    run_instr("lw",    7'b0000011, 3'd2, 7'b0000000, 32'd0, 32'd0, -1);
    run_instr("sw",    7'b0100011, 3'd2, 7'b0000000, 32'd0, 32'd0, -1);
    run_instr("blt_t", 7'b1100011, 3'd4, 7'b0000000, 32'd1, 32'd5, -1);
    run_instr("blt_n", 7'b1100011, 3'd4, 7'b0000000, 32'd5, 32'd1, -1);
    run_instr("bgeu",  7'b1100011, 3'd7, 7'b0000000, 32'd9, 32'd9, -1);
    run_instr("jal",   7'b1101111, 3'd0, 7'b0000000, 32'd0, 32'd0, -1);
    run_instr("jalr",  7'b1100111, 3'd0, 7'b0000000, 32'd0, 32'd0, -1);
    run_instr("lui",   7'b0110111, 3'd0, 7'b0000000, 32'd0, 32'd0, -1);
    run_instr("auipc", 7'b0010111, 3'd0, 7'b0000000, 32'd0, 32'd0, -1);
    run_instr("nop",   7'b1111111, 3'd0, 7'b0000000, 32'd0, 32'd0, -1);
    run_instr("lw_ab", 7'b0000011, 3'd2, 7'b0000000, 32'd0, 32'd0, 3);
    do_reset("mid", 2);
    run_instr("after", 7'b0100011, 3'd2, 7'b0000000, 32'd0, 32'd0, -1);

    for (int i = 0; i < 400; i++) begin
      int abort_at;
      a = pick_val();
      b = ($urandom_range(0, 3) == 0) ? a : pick_val();
      abort_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 4)) : -1;
      run_instr($sformatf("rnd%0d", i), ops[$urandom_range(0, 12)],
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 4) == 4) ? 7'($urandom) : f7s[$urandom_range(0, 3)],
                a, b, abort_at);
      if (abort_at >= 0) do_reset($sformatf("rnd%0d_rst", i), int'($urandom_range(1, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control unit of the word-addressed RV32I(+M) multi-cycle core.
- Sequences fetch/decode/execute/memory/writeback states and drives the datapath.
- Datapath it drives: PC, IR/OldPC, ALU, registered ALUOut, registered memory-data Data, and the result mux that feeds PC, register writeback and the memory address.
- Consumes IR fields and ALU comparison flags; contains no datapath registers.

Parameters:
- none (all encodings are constants in the shared package)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces FETCH
- OpCode  in  7  Inst[6:0]
- funct3  in  3  Inst[14:12]
- funct7  in  7  Inst[31:25]
- Eq  in  1  ALU A==B
- Gt  in  1  ALU signed A>B
- GtU  in  1  ALU unsigned A>B
- PCWrite  out  1  PC <= Result
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  Inst <= MemData, OldPC <= PC
- ResultSrc  out  2  00=ALUOut (registered), 01=Data (registered), 10=ALUResult (combinational)
- ALUControl  out  5  ALU operation
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=Reg1, 11=zero
- ALUSrcB  out  2  00=Reg2, 01=Imm, 10=constant 1
- RegWrite  out  1  register-file write enable

Behaviour:
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
- Outputs not listed for a state are 0 / don't-care: ALUControl=ADD, selects 0.
- Outputs are Moore, except branch PCWrite, which is combinational from Eq/Gt/GtU.
- While reset=0: state=FETCH and all write enables (PCWrite, IRWrite, MemWrite, RegWrite) are 0. Reset may be asserted mid-instruction; the partial instruction is abandoned.
- FETCH: AdrSrc=0, IRWrite=1, A=PC, B=1, ADD, ResultSrc=10, PCWrite=1 (PC+1). Next: DECODE.
- DECODE: A=OldPC, B=Imm, ADD, so ALUOut=branch/JAL target. Next state by OpCode:
  - 0110011 -> EXE_R
  - 0010011 -> EXE_I
  - 0000011 / 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 0110111 -> LUI
  - 0010111 -> ALUWB (AUIPC; ALUOut already holds OldPC+Imm)
  - anything else -> FETCH (NOP)
- EXE_R: A=Reg1, B=Reg2. funct7=0000001 selects M ops by funct3. Otherwise funct3 selects the op, with funct7[5] giving SUB (000) or SRA (101). Next: ALUWB.
- EXE_I: A=Reg1, B=Imm. funct3 000 is always ADD. 101 uses funct7[5] for SRA. No M ops. Next: ALUWB.
- LUI: A=zero, B=Imm, ADD. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- MEMADR: A=Reg1, B=Imm, ADD. Next: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
- Loads and stores are word-only; funct3 is ignored.
- BRANCH: A=Reg1, B=Reg2, SUB, ResultSrc=00. PCWrite=taken. Next: FETCH.
  - funct3 000: Eq
  - 001: !Eq
  - 100: !Gt&!Eq
  - 101: Gt|Eq
  - 110: !GtU&!Eq
  - 111: GtU|Eq
  - 010/011: never taken
- JAL: ResultSrc=00, PCWrite=1 (PC=target). Same cycle: A=OldPC, B=1, ADD into ALUOut. Next: ALUWB.
- JALR1: A=Reg1, B=Imm, ADD, ResultSrc=10, PCWrite=1. Next: JALR2.
- JALR2: A=OldPC, B=1, ADD, ResultSrc=10, RegWrite=1. Next: FETCH. Correct when rd==rs1.
- Latency in cycles, including fetch: R/I/LUI 4, AUIPC 3, load 5, store 4, branch 3, JAL 4, JALR 4.

Decomposition:
- Shared package: state enum; ALUControl codes; AdrSrc, ALUSrcA, ALUSrcB and ResultSrc select constants; opcode constants.
- Sub-module alu_op_decode: combinational map from (funct3, funct7, is_rtype) to ALUControl.

Test Plan:
- reset=0 held 3 cycles, then released -> state FETCH; PCWrite/IRWrite/MemWrite/RegWrite all 0 during reset. First post-reset cycle: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- OpCode 0110011, funct3 000, funct7 0100000 -> EXE_R shows ALUControl=1 (SUB), A=10, B=00. Next cycle RegWrite=1, ResultSrc=00. Total 4 cycles.
- OpCode 0110011, funct7 0000001, funct3 100 -> ALUControl=14 (DIV).
- OpCode 0010011, funct3 000, funct7 0100000 -> ALUControl=0 (ADDI, not SUB).
- Load (0000011) -> sequence FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1).
- Store (0100011) -> sequence FETCH, DECODE, MEMADR, MEMWRITE with MemWrite=1 for exactly one cycle.
- BLT (funct3 100) in BRANCH: Gt=0, Eq=0 -> PCWrite=1. Gt=1 -> PCWrite=0. BGEU with Eq=1 -> PCWrite=1.
- JAL: JAL state has PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10. Next cycle RegWrite=1.
- JALR: JALR1 PCWrite=1, ResultSrc=10. Then JALR2 RegWrite=1, ALUSrcA=01.
- Unknown opcode 1111111 -> DECODE then FETCH, with no RegWrite/MemWrite.
